piso_serial_tx: RTL
===================

Name: piso_serial_tx

Overview:
- Parallel-in/serial-out transmitter: captures a WIDTH-bit word via a valid/ready load handshake and drives it one bit at a time on complementary outputs q/q_bar.
- Paired with the D-flip-flop receive chain (d/clk capture, q/q_bar outputs): this block feeds serial bits into those flops.
- Serial side uses valid/ready so the receiving end can stall.
- Back-to-back words stream with no idle bit between them.

Parameters:
- WIDTH, 4, word width in bits; legal range 2..32.
- LSB_FIRST, 0, 0 = MSB sent first; 1 = LSB sent first.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  WIDTH  parallel word to transmit.
- ser_ready  input  1  receiver consumes the current bit this cycle.
- q  output  1  current serial bit (registered).
- q_bar  output  1  always the complement of q (registered).
- q_valid  output  1  q holds a bit of a word in flight (registered).
- last  output  1  current bit is the final bit of the word.
- busy  output  1  equals q_valid; for status and debug.

Behaviour:
- Reset: asynchronous on rst_n low; state IDLE, shift register and bit counter 0, q=0, q_bar=1, q_valid=0.
- Reset outputs: last=0, busy=0; load_ready=0 while rst_n low.
- Reset mid-word aborts the word immediately; no partial resume after release.
- States: IDLE and SHIFT.
- IDLE: load_ready=1, q_valid=0, q=0, q_bar=1.
- IDLE to SHIFT: on load_valid while in IDLE, at the clock edge:
  - load_data is captured;
  - q = first bit (MSB, or LSB if LSB_FIRST=1);
  - q_valid=1; bit counter cnt=0.
- Latency: first bit appears on q in the cycle after the load handshake.
- SHIFT: q holds while ser_ready=0 (stall, any length); q_bar tracks ~q at all times.
- Bit advance: q_valid and ser_ready high together means the bit is consumed. If cnt<WIDTH-1, q takes the next bit at the edge and cnt increments.
- last = q_valid and (cnt==WIDTH-1); combinational from registered state.
- Final bit consumed (last and ser_ready):
  - load_ready=1 combinationally in that cycle;
  - with load_valid: the new word loads at the same edge, its first bit appears next cycle, state stays SHIFT (zero-gap streaming);
  - without load_valid: next state IDLE, q_valid=0, q=0, q_bar=1.
- load_ready=0 in SHIFT except on a final-bit-consumed cycle. load_valid while load_ready=0 is ignored; the word is not captured and not queued.
- load_data may change freely when not handshaken.
- Each word takes exactly WIDTH accepted bits; no bit is dropped or duplicated under any ser_ready pattern.
- cnt width is clog2(WIDTH); it never exceeds WIDTH-1 and resets to 0 on every load.

Test Plan:
- Reset: hold rst_n=0 three cycles, pulse clk -> q=0, q_bar=1, q_valid=0, last=0, load_ready=0. Release -> load_ready=1.
- Single word: WIDTH=4, LSB_FIRST=0, ser_ready=1, load 4'b1011 -> from the next cycle q=1,0,1,1 with q_bar=0,1,0,0; last high only on the 4th bit; q_valid=0 in the following cycle.
- Stall: load 4'b0110, ser_ready=0 for 3 cycles after the first bit -> q stays 0 for 4 cycles, then bits 1,1,0 follow once ser_ready=1. Total bits seen = 4.
- Back-to-back: load_valid held with 4'hA then 4'h5, ser_ready=1 -> 8 consecutive valid bits 1010 0101. load_ready pulses on the 4th bit; q_valid has no gap.
- Ignored load: during bit 2 of 4'hF, assert load_valid with 4'h0 -> the word is not captured and the output remains 1111.
- Reset mid-word plus LSB_FIRST=1: load 4'b0001 (q=1), assert rst_n=0 asynchronously between edges -> q=0 and q_valid=0 immediately. After release, load 4'b1000 -> q=0,0,0,1.

Source files
------------

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter with valid/ready on both the load and serial sides.
// Words of WIDTH bits stream back-to-back with no idle bit when the next load is ready in time.
module piso_serial_tx #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_ready,
  output logic             q,
  output logic             q_bar,
  output logic             q_valid,
  output logic             last,
  output logic             busy
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             q_bar_q, q_bar_d;
  logic             load_fire, bit_take;

  assign q_valid    = (state_q == SHIFT);
  assign busy       = q_valid;
  assign last       = q_valid && (cnt_q == CNT_LAST);
  // Gated by rst_n so no word is offered a handshake while reset is asserted.
  assign load_ready = rst_n && ((state_q == IDLE) || (last && ser_ready));
  assign load_fire  = load_valid && load_ready;
  assign bit_take   = q_valid && ser_ready;
  assign q          = q_q;
  assign q_bar      = q_bar_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    if (load_fire) begin
      // A load during SHIFT only happens on the final-bit-consumed cycle.
      state_d = SHIFT;
      cnt_d   = '0;
      if (LSB_FIRST) begin
        q_d     = load_data[0];
        shreg_d = load_data >> 1;
      end else begin
        q_d     = load_data[WIDTH-1];
        shreg_d = load_data << 1;
      end
    end else if (bit_take) begin
      if (last) begin
        state_d = IDLE;
        cnt_d   = '0;
        q_d     = 1'b0;
      end else begin
        cnt_d = cnt_q + CW'(1);
        if (LSB_FIRST) begin
          q_d     = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end else begin
          q_d     = shreg_q[WIDTH-1];
          shreg_d = shreg_q << 1;
        end
      end
    end
    q_bar_d = ~q_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      q_bar_q <= 1'b1;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      q_bar_q <= q_bar_d;
    end
  end

endmodule
